// File: rtl/pipe_test_pkg.sv
// Shared pattern definitions for the pipe-in checker and pipe-out generator.
// Mode encodings, LFSR taps/seed and the load/next-pattern helpers.
package pipe_test_pkg;

  typedef enum logic [1:0] {
    MODE_LFSR  = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_WALK  = 2'd2,
    MODE_FIXED = 2'd3
  } pat_mode_e;

  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  // x^32+x^22+x^2+x+1, taken from bits 31/21/1/0.
  localparam int unsigned TAP_A = 31;
  localparam int unsigned TAP_B = 21;
  localparam int unsigned TAP_C = 1;
  localparam int unsigned TAP_D = 0;

  function automatic logic [31:0] width_mask(
    input int unsigned dw
  );
    logic [31:0] m;
    if (dw >= 32) m = '1;
    else          m = (32'd1 << dw) - 32'd1;
    return m;
  endfunction

  function automatic logic [31:0] pattern_load(
    input pat_mode_e   m,
    input logic [31:0] seed,
    input int unsigned dw
  );
    logic [31:0] v;
    unique case (m)
      MODE_LFSR:  v = (seed == 32'd0) ? LFSR_SEED : seed;
      MODE_COUNT: v = seed & width_mask(dw);
      MODE_WALK:  v = 32'd1;
      default:    v = seed;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] pattern_next(
    input pat_mode_e   m,
    input logic [31:0] g,
    input int unsigned dw
  );
    logic [31:0] v;
    logic [31:0] sh;
    sh = g >> (dw - 1);
    unique case (m)
      MODE_LFSR: v = {g[30:0],
                      g[TAP_A] ^ g[TAP_B] ^ g[TAP_C] ^ g[TAP_D]};
      MODE_COUNT: v = (g + 32'd1) & width_mask(dw);
      MODE_WALK: v = ((g << 1) | {31'd0, sh[0]})
                     & width_mask(dw);
      default: v = g;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/pipe_pattern_gen.sv
// 32-bit expected-pattern generator with load/advance; shared by both pipe ends.
// Ports: load_i/mode_i/seed_i reload, adv_i steps, word_o = gen[DATA_W-1:0].
module pipe_pattern_gen #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic [1:0]        mode_i,
  input  logic [31:0]       seed_i,
  input  logic              adv_i,
  output logic [DATA_W-1:0] word_o
);
  import pipe_test_pkg::*;

  pat_mode_e   mode_q, mode_d;
  logic [31:0] gen_q, gen_d;

  always_comb begin
    mode_d = mode_q;
    gen_d  = gen_q;
    if (load_i) begin
      mode_d = pat_mode_e'(mode_i);
      gen_d  = pattern_load(pat_mode_e'(mode_i),
                            seed_i, DATA_W);
    end else if (adv_i) begin
      gen_d = pattern_next(mode_q, gen_q, DATA_W);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MODE_LFSR;
      gen_q  <= LFSR_SEED;
    end else begin
      mode_q <= mode_d;
      gen_q  <= gen_d;
    end
  end

  assign word_o = gen_q[DATA_W-1:0];

endmodule

// File: rtl/pipe_in_checker_p.sv
// PipeIn checker: throttled ready, pattern compare, counters, first-error capture.
// Inputs: restart/mode/seed, throttle_set/val, pipe_in_write/data; outputs: status.
module pipe_in_checker_p #(
  parameter int DATA_W     = 16,
  parameter int THROTTLE_W = 32,
  parameter int ERR_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  restart,
  input  logic [1:0]            mode,
  input  logic [31:0]           seed,
  input  logic                  throttle_set,
  input  logic [THROTTLE_W-1:0] throttle_val,
  input  logic                  pipe_in_write,
  input  logic [DATA_W-1:0]     pipe_in_data,
  output logic                  pipe_in_ready,
  output logic [ERR_W-1:0]      error_count,
  output logic                  error_flag,
  output logic [15:0]           overrun_count,
  output logic [31:0]           word_count,
  output logic [31:0]           first_err_index,
  output logic [DATA_W-1:0]     first_err_expected,
  output logic [DATA_W-1:0]     first_err_received
);
  import pipe_test_pkg::*;

  logic [THROTTLE_W-1:0] thr_q, thr_d;
  logic                  rdy_q, rdy_d;
  logic [ERR_W-1:0]      err_q, err_d;
  logic                  flag_q, flag_d;
  logic [15:0]           ovr_q, ovr_d;
  logic [31:0]           wc_q, wc_d;
  logic [31:0]           fidx_q, fidx_d;
  logic [DATA_W-1:0]     fexp_q, fexp_d;
  logic [DATA_W-1:0]     frcv_q, frcv_d;

  logic              accept;
  logic              mism;
  logic [DATA_W-1:0] exp_word;

  // restart swallows a coincident write.
  assign accept = pipe_in_write & ~restart;
  assign mism   = accept & (pipe_in_data != exp_word);

  pipe_pattern_gen #(
    .DATA_W (DATA_W)
  ) u_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (restart),
    .mode_i  (mode),
    .seed_i  (seed),
    .adv_i   (accept),
    .word_o  (exp_word)
  );

  always_comb begin
    thr_d  = {thr_q[0], thr_q[THROTTLE_W-1:1]};
    rdy_d  = thr_q[0];
    err_d  = err_q;
    flag_d = flag_q;
    ovr_d  = ovr_q;
    wc_d   = wc_q;
    fidx_d = fidx_q;
    fexp_d = fexp_q;
    frcv_d = frcv_q;
    if (throttle_set) thr_d = throttle_val;
    if (restart) begin
      err_d  = '0;
      flag_d = 1'b0;
      ovr_d  = '0;
      wc_d   = '0;
      fidx_d = '0;
      fexp_d = '0;
      frcv_d = '0;
    end else if (accept) begin
      wc_d = wc_q + 32'd1;
      if (!rdy_q && ovr_q != '1)
        ovr_d = ovr_q + 16'd1;
      if (mism) begin
        if (err_q != '1) err_d = err_q + ERR_W'(1);
        if (!flag_q) begin
          flag_d = 1'b1;
          fidx_d = wc_q;
          fexp_d = exp_word;
          frcv_d = pipe_in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      thr_q  <= '1;
      rdy_q  <= 1'b0;
      err_q  <= '0;
      flag_q <= 1'b0;
      ovr_q  <= '0;
      wc_q   <= '0;
      fidx_q <= '0;
      fexp_q <= '0;
      frcv_q <= '0;
    end else begin
      thr_q  <= thr_d;
      rdy_q  <= rdy_d;
      err_q  <= err_d;
      flag_q <= flag_d;
      ovr_q  <= ovr_d;
      wc_q   <= wc_d;
      fidx_q <= fidx_d;
      fexp_q <= fexp_d;
      frcv_q <= frcv_d;
    end
  end

  assign pipe_in_ready      = rdy_q;
  assign error_count        = err_q;
  assign error_flag         = flag_q;
  assign overrun_count      = ovr_q;
  assign word_count         = wc_q;
  assign first_err_index    = fidx_q;
  assign first_err_expected = fexp_q;
  assign first_err_received = frcv_q;

endmodule
